gshare_train_sched: RTL and testbench



---
 rtl/gshare_pkg.sv | 23 ++
 rtl/gshare_train_sched_if.sv | 46 ++++
 rtl/gshare_train_fifo.sv | 60 ++++++
 rtl/gshare_train_sched.sv | 100 ++++++++++
 tb/tb_gshare_train_sched.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gshare_pkg.sv
// Shared types and helpers for the gshare training scheduler: the queued
// training record and the width helper used for occupancy counters.
package gshare_pkg;

    localparam int GSHARE_N = 7;

    typedef struct packed {
        logic                taken;
        logic                mispredicted;
        logic [GSHARE_N-1:0] history;
        logic [GSHARE_N-1:0] pc;
    } train_entry_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/gshare_train_sched_if.sv
// Bundle of the execute-side training stream, the frontend lookup stream and
// the predictor-facing predict/train ports around the training scheduler.
interface gshare_train_sched_if #(
    parameter int N  = gshare_pkg::GSHARE_N,
    parameter int CW = gshare_pkg::clog2(4 + 1)
);
    logic         in_valid;
    logic         in_ready;
    logic         in_taken;
    logic         in_mispredicted;
    logic [N-1:0] in_history;
    logic [N-1:0] in_pc;

    logic         fe_predict_valid;
    logic [N-1:0] fe_predict_pc;
    logic         fe_predict_ready;

    logic         predict_valid;
    logic [N-1:0] predict_pc;

    logic         train_valid;
    logic         train_taken;
    logic         train_mispredicted;
    logic [N-1:0] train_history;
    logic [N-1:0] train_pc;

    logic [CW-1:0] count;

    // The scheduler sits on the slave side; execute/frontend drive the master side.
    modport slave (
        input  in_valid, in_taken, in_mispredicted, in_history, in_pc,
        input  fe_predict_valid, fe_predict_pc,
        output in_ready, fe_predict_ready, predict_valid, predict_pc,
        output train_valid, train_taken, train_mispredicted, train_history, train_pc,
        output count
    );

    modport master (
        output in_valid, in_taken, in_mispredicted, in_history, in_pc,
        output fe_predict_valid, fe_predict_pc,
        input  in_ready, fe_predict_ready, predict_valid, predict_pc,
        input  train_valid, train_taken, train_mispredicted, train_history, train_pc,
        input  count
    );

endinterface

// File: rtl/gshare_train_fifo.sv
// In-order synchronous FIFO of training records; the head is readable
// combinationally and a pushed entry becomes visible one cycle later.
module gshare_train_fifo
    import gshare_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  train_entry_t  i_data,
    input  logic          i_pop,
    output train_entry_t  o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    localparam int AW = clog2(DEPTH);

    train_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;

    // Storage needs no reset; occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (i_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rdPtr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/gshare_train_sched.sv
// Queues resolved-branch training for the gshare predictor and arbitrates the
// PHT between frontend lookups and training, stalling lookups during recovery.
module gshare_train_sched
    import gshare_pkg::*;
#(
    parameter int N         = GSHARE_N,
    parameter int DEPTH     = 4,
    parameter int SHARED    = 1,
    parameter int MAX_DEFER = 3
) (
    input  logic clk,
    input  logic reset,
    gshare_train_sched_if.slave io_sched
);

    localparam int CW = clog2(DEPTH + 1);

    train_entry_t  w_inEntry;
    train_entry_t  w_head;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic          w_push;
    logic          w_issue;
    logic          w_forced;
    logic          w_mpPending;

    logic [CW-1:0] r_mpCnt;
    logic [3:0]    r_deferCnt;

    assign w_inEntry = '{taken:        io_sched.in_taken,
                         mispredicted: io_sched.in_mispredicted,
                         history:      io_sched.in_history,
                         pc:           io_sched.in_pc};

    assign w_push      = io_sched.in_valid & ~w_full;
    assign w_forced    = (r_deferCnt == 4'(MAX_DEFER));
    assign w_mpPending = (r_mpCnt != '0);

    // A pending mispredict drains the queue ahead of lookups so the history
    // rewrite reaches the predictor before any further prediction.
    always_comb begin
        w_issue = 1'b0;
        if (!w_empty) begin
            w_issue = (SHARED == 0) | ~io_sched.fe_predict_valid | w_mpPending | w_forced;
        end
    end

    gshare_train_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_inEntry),
        .i_pop   (w_issue),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Counts queued mispredicts; a push and a pop of one in the same cycle cancel.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mpCnt <= '0;
        end else begin
            case ({w_push & io_sched.in_mispredicted, w_issue & w_head.mispredicted})
                2'b10:   r_mpCnt <= r_mpCnt + 1'b1;
                2'b01:   r_mpCnt <= r_mpCnt - 1'b1;
                default: r_mpCnt <= r_mpCnt;
            endcase
        end
    end

    // Starvation guard: a head that keeps losing to lookups eventually wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_deferCnt <= '0;
        end else if (w_empty || w_issue) begin
            r_deferCnt <= '0;
        end else if ((SHARED != 0) && !w_forced) begin
            r_deferCnt <= r_deferCnt + 1'b1;
        end
    end

    assign io_sched.in_ready         = ~w_full;
    assign io_sched.fe_predict_ready = ~w_mpPending & ~((SHARED != 0) & w_issue & w_forced);
    assign io_sched.predict_valid    = io_sched.fe_predict_valid & io_sched.fe_predict_ready;
    assign io_sched.predict_pc       = io_sched.fe_predict_pc;

    assign io_sched.train_valid        = w_issue;
    assign io_sched.train_taken        = w_issue ? w_head.taken        : 1'b0;
    assign io_sched.train_mispredicted = w_issue ? w_head.mispredicted : 1'b0;
    assign io_sched.train_history      = w_issue ? w_head.history      : '0;
    assign io_sched.train_pc           = w_issue ? w_head.pc           : '0;
    assign io_sched.count              = w_count;

endmodule

// File: tb/tb_gshare_train_sched.sv
// Bench for gshare_train_sched: cycle vectors with constant expectations for a
// shared-PHT and a split-PHT instance, plus a scoreboard of issued training.
module tb_gshare_train_sched;
    import gshare_pkg::*;

    typedef struct {
        logic       dut;
        logic       rst;
        logic       iv;
        logic       tk;
        logic       mp;
        logic [6:0] hist;
        logic [6:0] pc;
        logic       fv;
        logic [6:0] fpc;
        logic       pv;
        logic       fr;
        logic       tv;
        logic [6:0] tpc;
        logic [2:0] cnt;
        logic       ir;
    } vec_t;

    logic       clk = 1'b0;
    logic       tbReset;
    logic       tbInValid;
    logic       tbTaken;
    logic       tbMp;
    logic [6:0] tbHist;
    logic [6:0] tbPc;
    logic       tbFeValid;
    logic [6:0] tbFePc;

    int compared   = 0;
    int mismatched = 0;

    train_entry_t sbShared[$];
    train_entry_t sbSplit[$];
    vec_t         vecs[$];

    gshare_train_sched_if #(.N(7), .CW(3)) bus1 ();
    gshare_train_sched_if #(.N(7), .CW(3)) bus0 ();

    assign bus1.in_valid         = tbInValid;
    assign bus1.in_taken         = tbTaken;
    assign bus1.in_mispredicted  = tbMp;
    assign bus1.in_history       = tbHist;
    assign bus1.in_pc            = tbPc;
    assign bus1.fe_predict_valid = tbFeValid;
    assign bus1.fe_predict_pc    = tbFePc;
    assign bus0.in_valid         = tbInValid;
    assign bus0.in_taken         = tbTaken;
    assign bus0.in_mispredicted  = tbMp;
    assign bus0.in_history       = tbHist;
    assign bus0.in_pc            = tbPc;
    assign bus0.fe_predict_valid = tbFeValid;
    assign bus0.fe_predict_pc    = tbFePc;

    gshare_train_sched #(.N(7), .DEPTH(4), .SHARED(1), .MAX_DEFER(3)) dutShared (
        .clk      (clk),
        .reset    (tbReset),
        .io_sched (bus1)
    );

    gshare_train_sched #(.N(7), .DEPTH(4), .SHARED(0), .MAX_DEFER(3)) dutSplit (
        .clk      (clk),
        .reset    (tbReset),
        .io_sched (bus0)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        compared = compared + 1;
        if (act !== exp) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s (vec %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input int d, input int rst, input int iv, input int tk, input int mp,
                                input int hist, input int pc, input int fv, input int fpc,
                                input int pv, input int fr, input int tv, input int tpc,
                                input int cnt, input int ir);
        vec_t v;
        v.dut  = 1'(d);   v.rst = 1'(rst); v.iv  = 1'(iv);   v.tk  = 1'(tk);
        v.mp   = 1'(mp);  v.hist = 7'(hist); v.pc = 7'(pc);  v.fv  = 1'(fv);
        v.fpc  = 7'(fpc); v.pv  = 1'(pv);  v.fr  = 1'(fr);   v.tv  = 1'(tv);
        v.tpc  = 7'(tpc); v.cnt = 3'(cnt); v.ir  = 1'(ir);
        return v;
    endfunction

    // Inputs change just after the active edge so the DUT samples them stably.
    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        tbReset   = v.rst;
        tbInValid = v.iv;
        tbTaken   = v.tk;
        tbMp      = v.mp;
        tbHist    = v.hist;
        tbPc      = v.pc;
        tbFeValid = v.fv;
        tbFePc    = v.fpc;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        logic       pv, fr, tv, ir;
        logic [6:0] tpc, ppc;
        logic [2:0] cnt;
        @(negedge clk);
        if (v.dut) begin
            pv = bus1.predict_valid; fr = bus1.fe_predict_ready; tv = bus1.train_valid;
            tpc = bus1.train_pc; cnt = bus1.count; ir = bus1.in_ready; ppc = bus1.predict_pc;
        end else begin
            pv = bus0.predict_valid; fr = bus0.fe_predict_ready; tv = bus0.train_valid;
            tpc = bus0.train_pc; cnt = bus0.count; ir = bus0.in_ready; ppc = bus0.predict_pc;
        end
        checkVal("predict_valid",    idx, 32'(pv),  32'(v.pv));
        checkVal("fe_predict_ready", idx, 32'(fr),  32'(v.fr));
        checkVal("train_valid",      idx, 32'(tv),  32'(v.tv));
        checkVal("train_pc",         idx, 32'(tpc), 32'(v.tpc));
        checkVal("count",            idx, 32'(cnt), 32'(v.cnt));
        checkVal("in_ready",         idx, 32'(ir),  32'(v.ir));
        checkVal("predict_pc",       idx, 32'(ppc), 32'(v.fpc));
    endtask

    // Scoreboard: pop-and-compare before pushing so a same-cycle bypass is caught.
    always @(negedge clk) begin
        train_entry_t expE;
        if (tbReset) begin
            sbShared.delete();
            sbSplit.delete();
        end else begin
            if (bus1.train_valid) begin
                if (sbShared.size() == 0) begin
                    checkVal("sbShared_unexpected", -1, 32'(bus1.train_pc), 32'hFFFF_FFFF);
                end else begin
                    expE = sbShared.pop_front();
                    checkVal("sbShared_entry", -1, 32'({bus1.train_taken, bus1.train_mispredicted,
                             bus1.train_history, bus1.train_pc}), 32'(expE));
                end
            end else begin
                checkVal("sbShared_idle", -1, 32'({bus1.train_taken, bus1.train_mispredicted,
                         bus1.train_history, bus1.train_pc}), 32'(0));
            end
            if (bus0.train_valid) begin
                if (sbSplit.size() == 0) begin
                    checkVal("sbSplit_unexpected", -1, 32'(bus0.train_pc), 32'hFFFF_FFFF);
                end else begin
                    expE = sbSplit.pop_front();
                    checkVal("sbSplit_entry", -1, 32'({bus0.train_taken, bus0.train_mispredicted,
                             bus0.train_history, bus0.train_pc}), 32'(expE));
                end
            end else begin
                checkVal("sbSplit_idle", -1, 32'({bus0.train_taken, bus0.train_mispredicted,
                         bus0.train_history, bus0.train_pc}), 32'(0));
            end
            if (tbInValid && bus1.in_ready) begin
                sbShared.push_back('{taken: tbTaken, mispredicted: tbMp, history: tbHist, pc: tbPc});
            end
            if (tbInValid && bus0.in_ready) begin
                sbSplit.push_back('{taken: tbTaken, mispredicted: tbMp, history: tbHist, pc: tbPc});
            end
        end
    end

    initial begin
        tbReset = 1'b1; tbInValid = 1'b0; tbTaken = 1'b0; tbMp = 1'b0;
        tbHist = '0; tbPc = '0; tbFeValid = 1'b0; tbFePc = '0;

        // Idle after reset: lookups pass straight through.
        vecs.push_back(mk(1,0,0,0,0,'h00,'h00,1,'h0a, 1,1,0,'h00,0,1));
        // Single train starved by lookups: deferred three cycles, then forced.
        vecs.push_back(mk(1,0,1,1,0,'h00,'h0a,1,'h11, 1,1,0,'h00,0,1));
        vecs.push_back(mk(1,0,0,0,0,'h00,'h00,1,'h11, 1,1,0,'h00,1,1));
        vecs.push_back(mk(1,0,0,0,0,'h00,'h00,1,'h11, 1,1,0,'h00,1,1));
        vecs.push_back(mk(1,0,0,0,0,'h00,'h00,1,'h11, 1,1,0,'h00,1,1));
        vecs.push_back(mk(1,0,0,0,0,'h00,'h00,1,'h11, 0,0,1,'h0a,1,1));
        // Second train sees a full fresh deferral window, so the counter cleared.
        vecs.push_back(mk(1,0,1,0,0,'h01,'h0b,1,'h12, 1,1,0,'h00,0,1));
        vecs.push_back(mk(1,0,0,0,0,'h00,'h00,1,'h12, 1,1,0,'h00,1,1));
        vecs.push_back(mk(1,0,0,0,0,'h00,'h00,1,'h12, 1,1,0,'h00,1,1));
        vecs.push_back(mk(1,0,0,0,0,'h00,'h00,1,'h12, 1,1,0,'h00,1,1));
        vecs.push_back(mk(1,0,0,0,0,'h00,'h00,1,'h12, 0,0,1,'h0b,1,1));
        vecs.push_back(mk(1,0,0,0,0,'h00,'h00,0,'h00, 0,1,0,'h00,0,1));
        // Fill to DEPTH behind lookups; full blocks the 5th even on a dequeue cycle.
        vecs.push_back(mk(1,0,1,0,0,'h01,'h20,1,'h13, 1,1,0,'h00,0,1));
        vecs.push_back(mk(1,0,1,1,0,'h02,'h21,1,'h13, 1,1,0,'h00,1,1));
        vecs.push_back(mk(1,0,1,0,0,'h03,'h22,1,'h13, 1,1,0,'h00,2,1));
        vecs.push_back(mk(1,0,1,1,0,'h04,'h23,1,'h13, 1,1,0,'h00,3,1));
        vecs.push_back(mk(1,0,1,0,0,'h05,'h24,1,'h13, 0,0,1,'h20,4,0));
        vecs.push_back(mk(1,0,1,0,0,'h05,'h24,0,'h13, 0,1,1,'h21,3,1));
        vecs.push_back(mk(1,0,0,0,0,'h00,'h00,0,'h00, 0,1,1,'h22,3,1));
        vecs.push_back(mk(1,0,0,0,0,'h00,'h00,0,'h00, 0,1,1,'h23,2,1));
        vecs.push_back(mk(1,0,0,0,0,'h00,'h00,0,'h00, 0,1,1,'h24,1,1));
        vecs.push_back(mk(1,0,0,0,0,'h00,'h00,0,'h00, 0,1,0,'h00,0,1));
        // Mispredict blocks lookups through its own issue cycle.
        vecs.push_back(mk(1,0,1,0,1,'h10,'h0a,1,'h14, 1,1,0,'h00,0,1));
        vecs.push_back(mk(1,0,0,0,0,'h00,'h00,1,'h14, 0,0,1,'h0a,1,1));
        vecs.push_back(mk(1,0,0,0,0,'h00,'h00,1,'h14, 1,1,0,'h00,0,1));
        // Mispredict queued behind a plain entry pulls both ahead of lookups.
        vecs.push_back(mk(1,0,1,1,0,'h21,'h30,1,'h15, 1,1,0,'h00,0,1));
        vecs.push_back(mk(1,0,1,1,1,'h22,'h31,1,'h15, 1,1,0,'h00,1,1));
        vecs.push_back(mk(1,0,0,0,0,'h00,'h00,1,'h15, 0,0,1,'h30,2,1));
        vecs.push_back(mk(1,0,0,0,0,'h00,'h00,1,'h15, 0,0,1,'h31,1,1));
        vecs.push_back(mk(1,0,0,0,0,'h00,'h00,1,'h15, 1,1,0,'h00,0,1));
        // Reset with three queued entries, one of them a mispredict.
        vecs.push_back(mk(1,0,1,0,0,'h01,'h40,1,'h16, 1,1,0,'h00,0,1));
        vecs.push_back(mk(1,0,1,0,0,'h02,'h41,1,'h16, 1,1,0,'h00,1,1));
        vecs.push_back(mk(1,0,1,1,1,'h03,'h42,1,'h16, 1,1,0,'h00,2,1));
        vecs.push_back(mk(1,1,0,0,0,'h00,'h00,1,'h16, 0,0,1,'h40,3,1));
        vecs.push_back(mk(1,0,0,0,0,'h00,'h00,1,'h16, 1,1,0,'h00,0,1));
        // Independent ports: predict and train proceed together.
        vecs.push_back(mk(0,0,1,1,0,'h05,'h50,1,'h17, 1,1,0,'h00,0,1));
        vecs.push_back(mk(0,0,1,0,0,'h06,'h51,1,'h17, 1,1,1,'h50,1,1));
        vecs.push_back(mk(0,0,0,0,0,'h00,'h00,1,'h17, 1,1,1,'h51,1,1));
        vecs.push_back(mk(0,0,0,0,0,'h00,'h00,1,'h17, 1,1,0,'h00,0,1));

        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        // Let the shared instance drain what the split-port vectors left queued.
        @(posedge clk);
        #1;
        tbInValid = 1'b0;
        tbFeValid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        checkVal("sbShared_drained", 0, 32'(sbShared.size()), 32'(0));
        checkVal("sbSplit_drained",  0, 32'(sbSplit.size()),  32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
